regfile_32x64: RTL and testbench
================================

# regfile_32x64

Architectural register file for the single-cycle/pipelined ARM datapath. Consumes the 32-bit one-hot write-select vector produced by the 5-to-32 write decoder, stores 32 × WIDTH registers with X31 hardwired to zero, and serves two combinational read ports to the operand-fetch stage. It also detects malformed (multi-hot) write-select vectors and latches a sticky error for debug.

## Interface
- WIDTH, 64, register data width in bits
- NUM_REGS, 32, register count; fixed at 32, matching the decoder output width
- clk  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- wr_sel  input  32  one-hot write select from the write decoder; bit i selects Xi; all-zero means no write
- wr_data  input  WIDTH  write-back data
- rd_addr_a  input  5  read port A register number
- rd_addr_b  input  5  read port B register number
- rd_data_a  output  WIDTH  read port A data
- rd_data_b  output  WIDTH  read port B data
- clr_err  input  1  synchronous clear of the sticky error flag
- err_multi_sel  output  1  sticky flag: a multi-hot wr_sel was seen

One clock (clk); reset is asynchronous and active-low (reset_n).

## Operation
- Storage: registers X0..X30 are real flops; X31 has no storage and always reads 0.
- Write qualification: eff_sel = wr_sel with bit 31 masked off. popcount(eff_sel) == 1 → write; == 0 → no write; ≥ 2 → write suppressed entirely (no register changes) and err_multi_sel sets.
- Write: on rising clk with a qualified write, the selected register takes wr_data.
- Reads: rd_data_x = 0 if rd_addr_x == 31, else the stored value of register rd_addr_x. Purely combinational from address and stored state.
- Error flag: set on any clk edge with popcount(eff_sel) ≥ 2; cleared on clk edge with clr_err = 1 and no new multi-hot event; simultaneous set and clear → set wins.
- wr_sel containing only bit 31 is a legal no-op, not an error.

## Timing
- Reset (reset_n low, asynchronous): all 31 registers → 0, err_multi_sel → 0; rd_data_a/b therefore read 0 immediately. Release is synchronised by the caller; first write accepted on the first rising edge with reset_n high.
- Write latency: data written at edge N is visible on read ports after edge N (same cycle as post-edge settle) when bypass is off.
- Read latency: zero cycles (combinational).
- Reset asserted in the same cycle as a write: reset wins, register stays 0.
- Both read ports may address the same register, including the one being written; each port behaves independently.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose rd_addr matches the register selected by a qualified write in the current cycle returns wr_data combinationally (write-to-read forwarding, for the half-cycle write-back/read pattern of the pipeline). Never bypasses for X31 or for a suppressed multi-hot write.
- REGFILE_BYPASS_EN undefined: read ports return stored values only; the pending write becomes visible after the clock edge.

## Structure
- Package regfile_pkg: NUM_REGS = 32, ZERO_REG = 5'd31, ADDR_W = 5, and typedef reg_addr_t (logic [4:0]).
- Sub-module reg_word: one WIDTH-bit register with write enable and asynchronous active-low reset; instantiated 31 times under a generate loop. Read muxes, popcount/qualification, bypass and error logic live in the top level.

## Test plan
- Reset: drive reset_n low mid-run after writing X5 = 0xDEAD → rd_addr_a = 5 reads 0 immediately, err_multi_sel = 0.
- Basic write/read: wr_sel = 1<<3, wr_data = 0x0123_4567_89AB_CDEF, one edge → rd_addr_a = 3 and rd_addr_b = 3 both read 0x0123_4567_89AB_CDEF; all other registers still 0.
- Zero register: wr_sel = 1<<31, wr_data = all-ones → rd_addr_a = 31 reads 0, err_multi_sel stays 0.
- Multi-hot: X1 = 0x11, X2 = 0x22 preloaded; wr_sel = 0x0000_0006, wr_data = 0xFF → X1 = 0x11, X2 = 0x22 unchanged, err_multi_sel = 1; next cycle clr_err = 1 with wr_sel = 0 → err_multi_sel = 0.
- Set/clear collision: clr_err = 1 with wr_sel = 0x0000_0003 → err_multi_sel = 1 after the edge.
- Bypass: wr_sel = 1<<7, wr_data = 0xAA, rd_addr_a = 7 before the edge → rd_data_a = 0xAA with REGFILE_BYPASS_EN, old value (0) without it; after the edge both builds read 0xAA.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry architectural register file.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

  function automatic logic multi_hot(
    input logic [NUM_REGS-1:0] sel
  );
    return |(sel & (sel - 1'b1));
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write-back / operand-fetch bundle of the register file.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
interface regfile_if #(
  parameter int WIDTH = 64
);
  import regfile_pkg::*;

  logic [NUM_REGS-1:0] wr_sel;
  logic [WIDTH-1:0]    wr_data;
  reg_addr_t           rd_addr_a;
  reg_addr_t           rd_addr_b;
  logic [WIDTH-1:0]    rd_data_a;
  logic [WIDTH-1:0]    rd_data_b;
  logic                clr_err;
  logic                err_multi_sel;

  modport master (
    output wr_sel,
    output wr_data,
    output rd_addr_a,
    output rd_addr_b,
    output clr_err,
    input  rd_data_a,
    input  rd_data_b,
    input  err_multi_sel
  );

  modport slave (
    input  wr_sel,
    input  wr_data,
    input  rd_addr_a,
    input  rd_addr_b,
    input  clr_err,
    output rd_data_a,
    output rd_data_b,
    output err_multi_sel
  );

endinterface

// File: rtl/regfile_32x64_reg_word.sv
// One WIDTH-bit architectural register with write enable.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module reg_word #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_32x64.sv
// 31 x WIDTH register file, X31 reads zero, multi-hot write guard.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_32x64
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      reset_n,
  regfile_if.slave  bus
);

  logic [NUM_REGS-1:0] w_eff_sel;
  logic                w_multi;
  logic                w_wr_ok;
  logic [WIDTH-1:0]    w_regs [NUM_REGS];
  logic                r_err;

  always_comb begin
    w_eff_sel           = bus.wr_sel;
    w_eff_sel[ZERO_REG] = 1'b0;
  end

  assign w_multi = multi_hot(w_eff_sel);
  assign w_wr_ok = (|w_eff_sel) & ~w_multi;

  for (genvar gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_we    (w_wr_ok & w_eff_sel[gi]),
      .i_d     (bus.wr_data),
      .o_q     (w_regs[gi])
    );
  end

  // X31 has no storage
  assign w_regs[ZERO_REG] = '0;

`ifdef REGFILE_BYPASS_EN
  // eff_sel has bit 31 masked, so X31 is never forwarded
  logic w_byp_a;
  logic w_byp_b;

  assign w_byp_a = w_wr_ok & w_eff_sel[bus.rd_addr_a];
  assign w_byp_b = w_wr_ok & w_eff_sel[bus.rd_addr_b];

  assign bus.rd_data_a = w_byp_a ? bus.wr_data
                                 : w_regs[bus.rd_addr_a];
  assign bus.rd_data_b = w_byp_b ? bus.wr_data
                                 : w_regs[bus.rd_addr_b];
`else
  assign bus.rd_data_a = w_regs[bus.rd_addr_a];
  assign bus.rd_data_b = w_regs[bus.rd_addr_b];
`endif

  // a new multi-hot event beats a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_multi) begin
      r_err <= 1'b1;
    end else if (bus.clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign bus.err_multi_sel = r_err;

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64 with a queue-based scoreboard.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module tb_regfile_32x64;
  import regfile_pkg::*;

  localparam int W = 64;

  localparam int P_A   = 0;
  localparam int P_B   = 1;
  localparam int P_ERR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [W-1:0] BYP_EXP = 64'hAA;
`else
  localparam logic [W-1:0] BYP_EXP = 64'h0;
`endif

  typedef struct {
    string        name;
    int           port;
    logic [W-1:0] exp;
  } exp_t;

  logic clk;
  logic reset_n;

  regfile_if #(.WIDTH(W)) bus ();

  regfile_32x64 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] act;
  int           errors = 0;
  int           checks = 0;

  // monitor: outputs are sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        P_A:     act = bus.rd_data_a;
        P_B:     act = bus.rd_data_b;
        default: act = {{(W-1){1'b0}}, bus.err_multi_sel};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h",
                 e.name, act, e.exp);
      end
    end
  end

  task automatic push(input string n, input int p,
                      input logic [W-1:0] x);
    exp_t t;
    t.name = n;
    t.port = p;
    t.exp  = x;
    sb.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] sel,
                       input logic [W-1:0] d,
                       input logic clr);
    bus.wr_sel  = sel;
    bus.wr_data = d;
    bus.clr_err = clr;
  endtask

  task automatic rd(input reg_addr_t a, input reg_addr_t b);
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(32'h0, '0, 1'b0);
    rd(5'd0, 5'd0);
    cyc();
    cyc();
    rd(5'd0, 5'd5);
    push("rst_x0", P_A, 64'h0);
    push("rst_x5", P_B, 64'h0);
    push("rst_err", P_ERR, 64'h0);
    cyc();
    reset_n = 1'b1;

    // basic write / read on both ports
    cyc();
    drive(32'h1 << 3, 64'h0123_4567_89AB_CDEF, 1'b0);
    cyc();
    drive(32'h0, '0, 1'b0);
    rd(5'd3, 5'd3);
    push("x3_a", P_A, 64'h0123_4567_89AB_CDEF);
    push("x3_b", P_B, 64'h0123_4567_89AB_CDEF);
    cyc();
    rd(5'd4, 5'd2);
    push("x4_zero", P_A, 64'h0);
    push("x2_zero", P_B, 64'h0);

    // X31 only: legal no-op
    cyc();
    drive(32'h8000_0000, '1, 1'b0);
    rd(5'd31, 5'd30);
    push("x31_pre", P_A, 64'h0);
    cyc();
    drive(32'h0, '0, 1'b0);
    push("x31_post", P_A, 64'h0);
    push("x30_zero", P_B, 64'h0);
    push("x31_noerr", P_ERR, 64'h0);

    // X31 plus one real register is still a single write
    cyc();
    drive(32'h8000_0200, 64'h99, 1'b0);
    cyc();
    drive(32'h0, '0, 1'b0);
    rd(5'd9, 5'd31);
    push("x9_b31", P_A, 64'h99);
    push("x31_b31", P_B, 64'h0);
    push("b31_noerr", P_ERR, 64'h0);

    // multi-hot suppression
    cyc();
    drive(32'h1 << 1, 64'h11, 1'b0);
    cyc();
    drive(32'h1 << 2, 64'h22, 1'b0);
    cyc();
    drive(32'h0000_0006, 64'hFF, 1'b0);
    rd(5'd1, 5'd2);
    push("mh_nobyp", P_A, 64'h11);
    cyc();
    drive(32'h0, '0, 1'b1);
    push("mh_x1", P_A, 64'h11);
    push("mh_x2", P_B, 64'h22);
    push("mh_err", P_ERR, 64'h1);
    cyc();
    drive(32'h0, '0, 1'b0);
    push("clr_err", P_ERR, 64'h0);

    // set and clear together: set wins
    cyc();
    drive(32'h0000_0003, 64'h77, 1'b1);
    cyc();
    drive(32'h0, '0, 1'b0);
    rd(5'd1, 5'd0);
    push("coll_err", P_ERR, 64'h1);
    push("coll_x1", P_A, 64'h11);
    push("coll_x0", P_B, 64'h0);
    cyc();
    drive(32'h0, '0, 1'b1);
    cyc();
    drive(32'h0, '0, 1'b0);
    push("coll_clr", P_ERR, 64'h0);

    // forwarding of the pending write
    cyc();
    drive(32'h1 << 7, 64'hAA, 1'b0);
    rd(5'd7, 5'd8);
    push("byp_pre", P_A, BYP_EXP);
    push("byp_other", P_B, 64'h0);
    cyc();
    drive(32'h0, '0, 1'b0);
    push("byp_post", P_A, 64'hAA);

    // reset mid-run clears data and error
    cyc();
    drive(32'h1 << 5, 64'hDEAD, 1'b0);
    cyc();
    drive(32'h0000_0030, 64'h1, 1'b0);
    cyc();
    drive(32'h0, '0, 1'b0);
    rd(5'd5, 5'd3);
    push("pre_x5", P_A, 64'hDEAD);
    push("pre_err", P_ERR, 64'h1);
    cyc();
    reset_n = 1'b0;
    drive(32'h1 << 5, 64'h1234, 1'b0);
    push("arst_x5", P_A, 64'h0);
    push("arst_x3", P_B, 64'h0);
    push("arst_err", P_ERR, 64'h0);
    cyc();
    push("arst_wr_x5", P_A, 64'h0);
    drive(32'h0, '0, 1'b0);
    cyc();
    reset_n = 1'b1;
    cyc();
    push("post_rst_x5", P_A, 64'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) cyc();
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
